// File: rtl/ps2_rx_deserializer.sv
// ============================================================================
//  ps2_rx_deserializer : PS/2 device-to-host frame receiver (sync, deglitch,
//                        11-bit deserialise, parity/stop/timeout checking)
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_rx_deserializer #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  DATA   = 2'd1;
    localparam logic [1:0]  PARITY = 2'd2;
    localparam logic [1:0]  STOP   = 2'd3;

    localparam logic [7:0]  C_FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [15:0] C_TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    logic        clk_s1_q, clk_s2_q;
    logic        dat_s1_q, dat_s2_q;
    logic        filt_q, filt_d;
    logic        filt_dly_q;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        fall_q;

    logic [1:0]  state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        par_q, par_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        w_timeout;

    // Filtered clock only follows the synchronised pin after FILTER_LEN
    // consecutive cycles of disagreement.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 8'd0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == C_FILT_LAST) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
            fcnt_q     <= 8'd0;
            fall_q     <= 1'b0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            fcnt_q     <= fcnt_d;
            fall_q     <= filt_dly_q & ~filt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= 8'd0;
            bitcnt_q <= 3'd0;
            par_q    <= 1'b0;
            tcnt_q   <= 16'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // A timeout takes priority; it cannot coincide with a fall by construction.
    assign w_timeout = (state_q != IDLE) && !fall_q && (tcnt_q == C_TO_LAST);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        tcnt_d   = (state_q == IDLE || fall_q) ? 16'd0 : tcnt_q + 16'd1;

        if (w_timeout) begin
            state_d = IDLE;
            error_d = 1'b1;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    sr_d     = {dat_s2_q, sr_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^{sr_q, par_q})) begin
                        data_d  = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy  = (state_q != IDLE);
        data  = data_q;
        valid = valid_q;
        error = error_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_deserializer.sv
// ============================================================================
//  tb_ps2_rx_deserializer : randomized self-checking bench with a frame-level
//                           model of expected strobes, timing and held data
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_rx_deserializer;

    localparam int F = 4;
    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       error;
    logic       busy;

    ps2_rx_deserializer #(
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (data),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        bit         is_valid;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [7:0] model_data;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Every strobe cycle is logged; a strobe held two cycles shows up as an extra event.
    always @(negedge clk) begin
        ev_t e;
        if (reset === 1'b0 && (valid === 1'b1 || error === 1'b1)) begin
            check_val("strobe_excl", {31'd0, valid & error}, 32'd0);
            e.cyc      = cyc;
            e.is_valid = valid;
            e.d        = data;
            obs_q.push_back(e);
        end
    end

    // One PS/2 bit: data set while clock high, then a low phase; optional
    // 3-cycle high glitch inside the low phase.
    task automatic ps2_bit(input bit b, input int half, input bit glitch, output int fall_cyc);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        if (glitch) begin
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half - 11) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half, input int glitch_bit);
        bit    p;
        bit    stop;
        bit    good;
        bit    fr[11];
        int    fc;
        ev_t   e;
        p    = (($countones(b) % 2) == 0) ^ bad_par;
        stop = ~bad_stop;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = b[i];
        fr[9]  = p;
        fr[10] = stop;
        for (int i = 0; i < 11; i++) begin
            ps2_bit(fr[i], half, (i == glitch_bit), fc);
            if (i == 5) check_val("busy_mid", {31'd0, busy}, 32'd1);
        end
        ps2_data = 1'b1;
        good = stop && (($countones({b, p}) % 2) == 1);
        e.cyc      = fc + F + 4;
        e.is_valid = good;
        e.d        = b;
        exp_q.push_back(e);
        if (good) model_data = b;
    endtask

    task automatic settle_and_verify(input string tag);
        ev_t o;
        ev_t x;
        repeat (F + 12) @(negedge clk);
        check_val({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            x = exp_q.pop_front();
            o = obs_q.pop_front();
            check_val({tag, "_cyc"}, o.cyc, x.cyc);
            check_val({tag, "_kind"}, {31'd0, o.is_valid}, {31'd0, x.is_valid});
            if (x.is_valid) check_val({tag, "_evdata"}, {24'd0, o.d}, {24'd0, x.d});
        end
        exp_q.delete();
        obs_q.delete();
        check_val({tag, "_data"}, {24'd0, data}, {24'd0, model_data});
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         fc;
        ev_t        e;
        logic [7:0] rb;
        int         mode;
        int         half;
        int         gb;

        reset      = 1'b1;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        model_data = 8'h00;
        repeat (5) @(negedge clk);
        check_val("rst_data",  {24'd0, data}, 32'd0);
        check_val("rst_valid", {31'd0, valid}, 32'd0);
        check_val("rst_error", {31'd0, error}, 32'd0);
        check_val("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'h1C, 1'b0, 1'b0, 20, -1);
        settle_and_verify("good_1C");

        send_frame(8'h1C, 1'b1, 1'b0, 20, -1);
        settle_and_verify("badpar");
        send_frame(8'h1C, 1'b0, 1'b1, 20, -1);
        settle_and_verify("badstop");

        // Short idle low pulse must be filtered out.
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        settle_and_verify("idle_glitch");
        send_frame(8'hF0, 1'b0, 1'b0, 20, 3);
        settle_and_verify("glitch_F0");

        // Timeout measured from the cycle the FSM acts on the last fall,
        // i.e. where a valid for that fall would have landed.
        rb = 8'($urandom);
        ps2_bit(1'b0, 20, 1'b0, fc);
        for (int i = 0; i < 3; i++) ps2_bit(rb[i], 20, 1'b0, fc);
        ps2_data = 1'b1;
        check_val("busy_partial", {31'd0, busy}, 32'd1);
        e.cyc      = fc + F + 4 + T;
        e.is_valid = 1'b0;
        e.d        = 8'h00;
        exp_q.push_back(e);
        repeat (T) @(negedge clk);
        settle_and_verify("timeout");
        send_frame(8'h5A, 1'b0, 1'b0, 20, -1);
        settle_and_verify("after_to_5A");

        rb = 8'($urandom);
        ps2_bit(1'b0, 20, 1'b0, fc);
        for (int i = 0; i < 5; i++) ps2_bit(rb[i], 20, 1'b0, fc);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_data = 8'h00;
        settle_and_verify("midreset");
        send_frame(8'h12, 1'b0, 1'b0, 20, -1);
        settle_and_verify("after_rst_12");

        send_frame(8'hE0, 1'b0, 1'b0, 20, -1);
        send_frame(8'h75, 1'b0, 1'b0, 20, -1);
        settle_and_verify("b2b");

        for (int n = 0; n < 30; n++) begin
            rb   = 8'($urandom);
            mode = $urandom_range(0, 3);
            half = $urandom_range(10, 30);
            gb   = (half >= 12 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1;
            send_frame(rb, (mode == 0), (mode == 1), half, gb);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            settle_and_verify("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_rx_deserializer.md
Name: ps2_rx_deserializer

Overview:
PS/2 device-to-host serial receiver that sits directly upstream of the Aquarius keyboard front end. It synchronises and deglitches the raw ps2_clk/ps2_data pins and deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop. Each good frame produces a one-cycle valid strobe with the byte, and each bad frame a one-cycle error strobe. The downstream keyboard block latches data on valid.

Parameters:
FILTER_LEN, 8, consecutive clk cycles a synchronised ps2_clk level must persist before the filtered clock changes (1..255).
TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge, while a frame is in progress, before the frame is aborted (1..65535).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
data  output  8  last correctly received byte, held until the next good frame
valid  output  1  one-cycle strobe, data updated this cycle
error  output  1  one-cycle strobe on parity, stop-bit or timeout failure
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (clk, reset: synchronous, active-high): data=0x00, valid=0, error=0, busy=0; sync flops and filtered clock =1; filter/timeout/bit counters =0; state=IDLE. Reset mid-frame discards the partial frame with no strobe.
- Sync: 2-flop synchroniser on each pin; ps2_data sync output is used directly as the sampled bit.
- Filter: counter increments while sync clk != filtered clk, clears when equal. When it reaches FILTER_LEN, filtered clk takes the sync value and the counter clears. Pulses shorter than FILTER_LEN cycles are ignored.
- Edge: fall is a registered one-cycle pulse when filtered clk goes 1->0. The data bit is the sync data value in the cycle fall is high.
- FSM on fall:
  - IDLE: bit=0 -> DATA, bitcnt=0. bit=1 -> stay in IDLE, no strobe (spurious edge).
  - DATA: shift register sr <= {bit, sr[7:1]}, bitcnt++. After the 8th bit (bitcnt==7) -> PARITY.
  - PARITY: store bit p -> STOP.
  - STOP: if bit==1 and ^{sr,p}==1 (odd parity), next cycle data<=sr and valid=1; otherwise error=1 and data unchanged. Always -> IDLE.
- Timeout: counter clears in IDLE and on every fall, and increments otherwise. At TIMEOUT_CYCLES it forces IDLE and error=1 for one cycle.
- valid and error are never high together. Each frame yields at most one strobe.
- Latency: valid/error rise exactly FILTER_LEN+4 clk cycles after the stop-bit falling edge at the pin (sync 2 + filter FILTER_LEN + fall register 1 + output 1).
- busy rises the cycle after the start-bit fall and drops the cycle the strobe is asserted.
- Back-to-back frames need no idle gap beyond the normal stop-bit high time.
- No host-to-device transmit; pins are input only.

Test Plan:
Bench setup: FILTER_LEN=4, TIMEOUT_CYCLES=1000, PS/2 half-period 20 clk.
- Frame 0x1C, parity 0, stop 1 -> valid for exactly 1 cycle, data=0x1C, error=0; valid rises 8 clks after the stop-bit fall; busy low afterwards.
- Frame 0x1C with parity 1, then frame 0x1C with stop 0 -> each gives error for 1 cycle, valid=0, data stays at its prior value.
- Idle ps2_clk low pulse of 3 clk, plus a 3-clk high glitch during a data bit -> no state change, no strobe; a following 0xF0 frame (parity 1) gives valid, data=0xF0.
- Start bit plus 3 data bits, then clock stops -> error exactly 1000 clk after the last fall, busy=0; the next 0x5A frame (parity 1) gives valid, data=0x5A.
- reset asserted for 1 cycle after the 5th data bit of a frame -> data=0x00, no strobe; the next frame 0x12 (parity 1) gives valid, data=0x12.
- Back-to-back 0xE0 (parity 0) and 0x75 (parity 0) -> two valid strobes, data=0xE0 then 0x75, no error.
